csr_trap_ctrl: RTL

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl_pkg.sv | 48 ++++
 rtl/csr_trap_ctrl_if.sv | 24 ++
 rtl/csr_trap_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants, state encoding and mstatus helpers for the trap controller.
package csr_trap_ctrl_pkg;

   localparam int unsigned XLEN = 32;

   // CSR addresses driven on the secondary write port
   localparam logic [XLEN-1:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [XLEN-1:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [XLEN-1:0] CSR_MCAUSE  = 32'h0000_0342;

   // mcause values
   localparam logic [XLEN-1:0] CAUSE_ECALL     = 32'd11;
   localparam logic [XLEN-1:0] CAUSE_EBREAK    = 32'd3;
   localparam logic [XLEN-1:0] CAUSE_TIMER_INT = 32'h8000_0007;

   // mstatus bit positions
   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_W_MEPC    = 3'd1,
      S_W_MCAUSE  = 3'd2,
      S_W_MSTATUS = 3'd3,
      S_T_JUMP    = 3'd4,
      S_R_MSTATUS = 3'd5,
      S_R_JUMP    = 3'd6
   } state_e;

   // Trap entry: stash MIE into MPIE and disable interrupts.
   function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r               = s;
      r[MSTATUS_MPIE] = s[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // Trap return: restore MIE from MPIE and set MPIE.
   function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r               = s;
      r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// CSR file connection: current CSR values in, secondary write port out.
interface csr_trap_ctrl_if;
   import csr_trap_ctrl_pkg::*;

   logic            ex_csr_wr_en_i;
   logic [XLEN-1:0] csr_mtvec_i;
   logic [XLEN-1:0] csr_mepc_i;
   logic [XLEN-1:0] csr_mstatus_i;
   logic            csr_wr_en_o;
   logic [XLEN-1:0] csr_wr_addr_o;
   logic [XLEN-1:0] csr_wr_data_o;

   // Trap controller side
   modport master (
      input  ex_csr_wr_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
      output csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o
   );

   // CSR file side
   modport slave (
      output ex_csr_wr_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
      input  csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o
   );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer: writes MEPC/MCAUSE/MSTATUS through the
// CSR file's secondary port one per cycle, then redirects the PC.
module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  int_req_i,
   input  logic                  ecall_i,
   input  logic                  ebreak_i,
   input  logic                  mret_i,
   input  logic [XLEN-1:0]       inst_addr_i,
   csr_trap_ctrl_if.master       csr_if,
   output logic                  hold_flag_o,
   output logic                  jump_flag_o,
   output logic [XLEN-1:0]       jump_addr_o
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] snap_q, snap_d;

   logic exc_c;
   logic irq_c;
   logic stall_c;

   // Event decode; the EX-stage CSR write owns the CSR file this cycle when active
   always_comb begin
      exc_c   = ecall_i | ebreak_i;
      irq_c   = int_req_i & csr_if.csr_mstatus_i[MSTATUS_MIE];
      stall_c = csr_if.ex_csr_wr_en_i;
   end

   // State and latched trap context
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         epc_q   <= '0;
         cause_q <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         snap_q  <= snap_d;
      end
   end

   // Next-state and Moore outputs; hold_flag_o is combinational only in IDLE
   always_comb begin
      state_d              = state_q;
      epc_d                = epc_q;
      cause_d              = cause_q;
      snap_d               = snap_q;
      hold_flag_o          = 1'b0;
      jump_flag_o          = 1'b0;
      jump_addr_o          = '0;
      csr_if.csr_wr_en_o   = 1'b0;
      csr_if.csr_wr_addr_o = '0;
      csr_if.csr_wr_data_o = '0;

      case (state_q)
         S_IDLE: begin
            if (exc_c || mret_i || irq_c) begin
               hold_flag_o = 1'b1;
               epc_d       = inst_addr_i;
               snap_d      = csr_if.csr_mstatus_i;
               if (exc_c) begin
                  cause_d = ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
                  state_d = S_W_MEPC;
               end else if (mret_i) begin
                  state_d = S_R_MSTATUS;
               end else begin
                  cause_d = CAUSE_TIMER_INT;
                  state_d = S_W_MEPC;
               end
            end
         end
         S_W_MEPC: begin
            hold_flag_o = 1'b1;
            if (!stall_c) begin
               csr_if.csr_wr_en_o   = 1'b1;
               csr_if.csr_wr_addr_o = CSR_MEPC;
               csr_if.csr_wr_data_o = epc_q;
               state_d              = S_W_MCAUSE;
            end
         end
         S_W_MCAUSE: begin
            hold_flag_o = 1'b1;
            if (!stall_c) begin
               csr_if.csr_wr_en_o   = 1'b1;
               csr_if.csr_wr_addr_o = CSR_MCAUSE;
               csr_if.csr_wr_data_o = cause_q;
               state_d              = S_W_MSTATUS;
            end
         end
         S_W_MSTATUS: begin
            hold_flag_o = 1'b1;
            if (!stall_c) begin
               csr_if.csr_wr_en_o   = 1'b1;
               csr_if.csr_wr_addr_o = CSR_MSTATUS;
               csr_if.csr_wr_data_o = trap_mstatus(snap_q);
               state_d              = S_T_JUMP;
            end
         end
         S_T_JUMP: begin
            hold_flag_o = 1'b1;
            jump_flag_o = 1'b1;
            jump_addr_o = csr_if.csr_mtvec_i & ~XLEN'(32'h3);
            state_d     = S_IDLE;
         end
         S_R_MSTATUS: begin
            hold_flag_o = 1'b1;
            if (!stall_c) begin
               csr_if.csr_wr_en_o   = 1'b1;
               csr_if.csr_wr_addr_o = CSR_MSTATUS;
               csr_if.csr_wr_data_o = mret_mstatus(snap_q);
               state_d              = S_R_JUMP;
            end
         end
         S_R_JUMP: begin
            hold_flag_o = 1'b1;
            jump_flag_o = 1'b1;
            jump_addr_o = csr_if.csr_mepc_i;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
